ula_sequencial: RTL and testbench
=================================

// Module: ula_sequencial
// PURPOSE
//  Parametrised multi-cycle ALU with integrated operation decode for the RISC-V core.
//  Decodes ULAOp/funct3/funct7 like the combinational ALU control, and adds a full RV32I+MUL op set.
//  Executes shifts iteratively (SHIFT_STEP bits/cycle) and MUL by shift-add; ADD/SUB/logic complete in one cycle.
//  Sits in EX stage; start/busy/done handshake lets the control FSM stall the datapath.
// PARAMETERS
//  XLEN        32  operand/result width (>=8, power of 2)
//  SHIFT_STEP  1   max bit positions shifted per cycle (1..XLEN)
//  ENABLE_MUL  1   1: MUL supported; 0: MUL decodes as illegal
// PORTS
//  clk          in   1          single clock, all state on rising edge
//  rst_n        in   1          synchronous reset, active low
//  start        in   1          request; sampled only when accepting (state IDLE or DONE)
//  ULAOp        in   2          00 load/store add, 01 branch, 10 R-type, 11 I-type
//  funct3       in   3          instruction funct3
//  funct7_bit5  in   1          SUB/SRA select
//  funct7_bit0  in   1          M-extension select (R-type only)
//  op_a         in   XLEN       operand A
//  op_b         in   XLEN       operand B / immediate; shamt = op_b[$clog2(XLEN)-1:0]
//  busy         out  1          high in SHIFT or MUL states
//  done         out  1          one-cycle pulse, result/zero/illegal valid
//  result       out  XLEN       registered result, held until next done
//  zero         out  1          (result == 0), updated with result
//  illegal      out  1          undefined encoding, valid with done
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state=IDLE, busy=0, done=0, result=0, zero=0, illegal=0; in-flight op aborted, no done.
//  Decode: 00->ADD; 01->SUB; 10: f3 000 f0=1 MUL, f5 SUB else ADD; 001 SLL; 100 XOR;
//   101 f5 SRA else SRL; 110 OR; 111 AND; others illegal. 11: 000 ADD, 001 SLL, 100 XOR,
//   101 f5 SRA else SRL, 110 OR, 111 AND; 010/011 illegal. Illegal: result=0, zero=1, illegal=1.
//  R-type funct7_bit0=1 with funct3!=000, or MUL with ENABLE_MUL=0 -> illegal.
//  Operands and decoded op captured at accepting edge; later input changes ignored.
//  FSM: IDLE -start-> DONE (1-cycle op, shamt=0 shift, illegal) | SHIFT (shamt>0) | MUL.
//   SHIFT: each cycle shift by min(SHIFT_STEP, remaining); remaining hits 0 -> DONE.
//   MUL: XLEN iterations, one multiplier bit each; after last -> DONE. Result = low XLEN bits.
//   DONE: done=1 for exactly that cycle; start accepted -> new op (back-to-back), else IDLE.
//  Latency (accept edge to done high): 1 for 1-cycle ops; 1+ceil(shamt/SHIFT_STEP) shifts; XLEN+1 MUL.
//  start while busy=1 ignored, no queueing. done and busy never both high.
//  Arithmetic modulo 2^XLEN; no overflow flag. SRA replicates op_a[XLEN-1]; SRL/SLL fill zeros.
//  result/zero/illegal written only on entry to DONE; held otherwise (incl. IDLE).
// TESTING
//  Reset: rst_n=0 one edge with start=1 -> busy=0, done=0, result=0 next cycle.
//  ULAOp=10,f3=000,f5=1, a=5,b=7 -> done 1 cycle later, result=0xFFFFFFFE, zero=0.
//  ULAOp=01, a=b=0x1234 -> result=0, zero=1 after 1 cycle; back-to-back start in DONE accepted.
//  SRA, STEP=1, a=0x80000000, b=4 -> busy 4 cycles, done at 5th, result=0xF8000000; shamt=0 -> 1 cycle.
//  MUL a=0xFFFFFFFF,b=3 -> done after 33 cycles, result=0xFFFFFFFD; start pulses mid-op ignored.
//  ULAOp=11,f3=010 -> done after 1, illegal=1, result=0; rst_n=0 mid-MUL -> no done, outputs reset.

Source files
------------

// File: rtl/ula_sequencial.sv
// Multi-cycle ALU for the EX stage: decodes ULAOp/funct3/funct7 itself,
// does ADD/SUB/logic in one cycle, shifts SHIFT_STEP bits per cycle and
// multiplies by shift-add. start/busy/done lets the control FSM stall.
module ula_sequencial #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int ENABLE_MUL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      ULAOp,
    input  logic [2:0]      funct3,
    input  logic            funct7_bit5,
    input  logic            funct7_bit0,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP_C = CW'(SHIFT_STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_SRA,
        OP_XOR, OP_OR, OP_AND, OP_MUL, OP_ILL
    } op_t;

    state_t          state_q, state_d;
    op_t             op_q, op_d, dec_op;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d, amt;
    logic [XLEN-1:0] result_q, result_d, one_res, sh_val, acc_add;
    logic            zero_q, zero_d, illegal_q, illegal_d;
    logic            accept, go_shift, go_mul;
    logic [SW-1:0]   shamt;

    assign shamt  = op_b[SW-1:0];
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    // Register all state; synchronous active-low reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end

    // Decode the instruction fields into an internal operation.
    always_comb begin
        dec_op = OP_ILL;
        case (ULAOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                case (funct3)
                    3'b000: begin
                        if (funct7_bit0) dec_op = (ENABLE_MUL != 0) ? OP_MUL : OP_ILL;
                        else             dec_op = funct7_bit5 ? OP_SUB : OP_ADD;
                    end
                    3'b001:  dec_op = OP_SLL;
                    3'b100:  dec_op = OP_XOR;
                    3'b101:  dec_op = funct7_bit5 ? OP_SRA : OP_SRL;
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    default: dec_op = OP_ILL;
                endcase
                // M-extension bit only meaningful for MUL
                if (funct7_bit0 && funct3 != 3'b000) dec_op = OP_ILL;
            end
            default: begin
                case (funct3)
                    3'b000:  dec_op = OP_ADD;
                    3'b001:  dec_op = OP_SLL;
                    3'b100:  dec_op = OP_XOR;
                    3'b101:  dec_op = funct7_bit5 ? OP_SRA : OP_SRL;
                    3'b110:  dec_op = OP_OR;
                    3'b111:  dec_op = OP_AND;
                    default: dec_op = OP_ILL;
                endcase
            end
        endcase
        go_shift = (dec_op == OP_SLL || dec_op == OP_SRL || dec_op == OP_SRA) && (shamt != '0);
        go_mul   = (dec_op == OP_MUL);
    end

    // Single-cycle results straight from the inputs; shifts reaching here have shamt=0.
    always_comb begin
        case (dec_op)
            OP_ADD:  one_res = op_a + op_b;
            OP_SUB:  one_res = op_a - op_b;
            OP_XOR:  one_res = op_a ^ op_b;
            OP_OR:   one_res = op_a | op_b;
            OP_AND:  one_res = op_a & op_b;
            OP_SLL, OP_SRL, OP_SRA: one_res = op_a;
            default: one_res = '0;
        endcase
    end

    // Next-state logic of the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (go_shift)    state_d = S_SHIFT;
                    else if (go_mul) state_d = S_MUL;
                    else             state_d = S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: if (cnt_q == amt)       state_d = S_DONE;
            S_MUL:   if (cnt_q == CW'(1))    state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in SHIFT/MUL, write result on entry to DONE.
    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        amt       = (cnt_q > STEP_C) ? STEP_C : cnt_q;
        case (op_q)
            OP_SLL:  sh_val = a_q << amt;
            OP_SRL:  sh_val = a_q >> amt;
            default: sh_val = $unsigned($signed(a_q) >>> amt);
        endcase
        acc_add = b_q[0] ? (acc_q + a_q) : acc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_d  = dec_op;
                    a_d   = op_a;
                    b_d   = op_b;
                    acc_d = '0;
                    if (go_shift) begin
                        cnt_d = {1'b0, shamt};
                    end else if (go_mul) begin
                        cnt_d = CW'(XLEN);
                    end else begin
                        result_d  = one_res;
                        zero_d    = (one_res == '0);
                        illegal_d = (dec_op == OP_ILL);
                    end
                end
            end
            S_SHIFT: begin
                a_d   = sh_val;
                cnt_d = cnt_q - amt;
                if (cnt_q == amt) begin
                    result_d  = sh_val;
                    zero_d    = (sh_val == '0);
                    illegal_d = 1'b0;
                end
            end
            S_MUL: begin
                acc_d = acc_add;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d  = acc_add;
                    zero_d    = (acc_add == '0);
                    illegal_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded from registered state only.
    always_comb begin
        busy    = (state_q == S_SHIFT) || (state_q == S_MUL);
        done    = (state_q == S_DONE);
        result  = result_q;
        zero    = zero_q;
        illegal = illegal_q;
    end
endmodule

// File: tb/tb_ula_sequencial.sv
// Directed bench for ula_sequencial (XLEN=32, SHIFT_STEP=1, MUL enabled).
module tb_ula_sequencial;
    logic        clk = 1'b0;
    logic        rst_n, start, f5, f0;
    logic [1:0]  ula_op;
    logic [2:0]  f3;
    logic [31:0] op_a, op_b, result;
    logic        busy, done, zero, illegal;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ula_sequencial #(.XLEN(32), .SHIFT_STEP(1), .ENABLE_MUL(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ULAOp(ula_op), .funct3(f3),
        .funct7_bit5(f5), .funct7_bit0(f0), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .result(result), .zero(zero), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the current negedge and follow it to done.
    task automatic run_op(input string tag, input logic [1:0] uop, input logic [2:0] fn3,
                          input logic b5, input logic b0, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_r, input logic exp_z,
                          input logic exp_i, input int exp_lat, input bit poke);
        int lat;
        int busy_cnt;
        ula_op = uop; f3 = fn3; f5 = b5; f0 = b0; op_a = a; op_b = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            start = poke && (lat < exp_lat - 1);
            if (poke) begin
                op_a = $urandom_range(0, 32'hFFFF);
                op_b = $urandom_range(0, 32'hFFFF);
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, busy_cnt, exp_lat - 1);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_result"}, result, exp_r);
        check({tag, "_zero"}, {31'b0, zero}, {31'b0, exp_z});
        check({tag, "_illegal"}, {31'b0, illegal}, {31'b0, exp_i});
    endtask

    initial begin
        int seen_done;
        // Reset with start held high: nothing may be accepted.
        rst_n = 1'b0; start = 1'b1; ula_op = 2'b00; f3 = 3'b000; f5 = 1'b0; f0 = 1'b0;
        op_a = 32'd1; op_b = 32'd2;
        @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_illegal", {31'b0, illegal}, 32'd0);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);

        // Single-cycle ops; consecutive calls exercise back-to-back accept in DONE.
        run_op("sub_r", 2'b10, 3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1'b0);
        run_op("beq", 2'b01, 3'b000, 1'b0, 1'b0, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        run_op("add_wrap", 2'b00, 3'b010, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b1, 1'b0, 1, 1'b0);
        run_op("xor_r", 2'b10, 3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, 1, 1'b0);
        run_op("or_i", 2'b11, 3'b110, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'h0000_0F0F, 32'hF0F0_FFFF, 1'b0, 1'b0, 1, 1'b0);
        run_op("and_r", 2'b10, 3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1, 1'b0);

        // No start after done: done drops, result held.
        @(negedge clk);
        check("idle_done", {31'b0, done}, 32'd0);
        check("idle_hold", result, 32'hF000_F000);

        // Shifts: 1 bit per cycle, shamt from op_b[4:0].
        run_op("sra4", 2'b10, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5, 1'b0);
        run_op("srl4_i", 2'b11, 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 5, 1'b0);
        run_op("sll0", 2'b11, 3'b001, 1'b0, 1'b0, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 1, 1'b0);
        run_op("sll31", 2'b10, 3'b001, 1'b0, 1'b0, 32'd3, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32, 1'b0);
        run_op("sra_hi_bits", 2'b11, 3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'h25, 32'hFC00_0000, 1'b0, 1'b0, 6, 1'b0);

        // MUL with start pulses and input changes while busy.
        run_op("mul_neg", 2'b10, 3'b000, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b0, 33, 1'b1);
        run_op("mul_small", 2'b10, 3'b000, 1'b0, 1'b1, 32'd7, 32'd6, 32'd42, 1'b0, 1'b0, 33, 1'b0);

        // Illegal encodings.
        run_op("ill_i010", 2'b11, 3'b010, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1, 1'b0);
        run_op("ill_m_xor", 2'b10, 3'b100, 1'b0, 1'b1, 32'd9, 32'd3, 32'd0, 1'b1, 1'b1, 1, 1'b0);
        run_op("ill_r011", 2'b10, 3'b011, 1'b0, 1'b0, 32'd9, 32'd3, 32'd0, 1'b1, 1'b1, 1, 1'b0);
        run_op("legal_after", 2'b00, 3'b000, 1'b0, 1'b0, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 1, 1'b0);

        // Reset in the middle of a MUL: no done, outputs cleared.
        ula_op = 2'b10; f3 = 3'b000; f5 = 1'b0; f0 = 1'b1; op_a = 32'd5; op_b = 32'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_mul_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_result", result, 32'd0);
        check("mrst_zero", {31'b0, zero}, 32'd0);
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        check("mrst_no_done", seen_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
